execute_cc_mreg: RTL and testbench
==================================

# execute_cc_mreg

Back half of the pipelined Y86-64 Execute stage, directly downstream of the 64-bit ALU. Holds the condition-code register, updated from the ALU flags `{ZF,SF,OF}`. Evaluates the jump/cmov condition from the registered codes. Latches the Execute results into the E→M pipeline register, with stall and bubble control, for the Memory stage.

## Interface
Parameters:
- `W`, 64, datapath width of valE/valA

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `E_icode`  in  4  instruction code in Execute
- `E_ifun`  in  4  function code in Execute
- `E_stat`  in  2  status in Execute: 00 AOK, 01 HLT, 10 ADR, 11 INS
- `E_valA`  in  W  operand forwarded to Memory
- `E_dstE`  in  4  ALU-result destination register
- `E_dstM`  in  4  load destination register
- `e_valE`  in  W  ALU result
- `e_cf`  in  3  ALU flags: [2]=ZF, [1]=SF, [0]=OF
- `m_stat`  in  2  status currently produced by Memory
- `W_stat`  in  2  status in Writeback
- `M_stall`  in  1  hold the M register
- `M_bubble`  in  1  load a NOP into the M register
- `e_cnd`  out  1  condition result (combinational)
- `e_dstE`  out  4  effective dstE; 4'hF when a cmov is not taken
- `cc`  out  3  current condition codes `{ZF,SF,OF}`
- `M_icode`, `M_stat`, `M_cnd`, `M_valE`, `M_valA`, `M_dstE`, `M_dstM`  out  4/2/1/W/W/4/4  registered E→M state

## Operation
- Icodes: HALT 0, NOP 1, CMOVXX 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B. RNONE = 4'hF.
- `set_cc = (E_icode==OPQ) && m_stat∈{AOK} && W_stat∈{AOK}`.
  - Any non-AOK status in Memory or Writeback blocks the CC update.
  - `E_stat` is not consulted.
- CC register:
  - Loads `e_cf` on a clock edge when `set_cc` is high; otherwise holds.
  - Reset value 3'b100 (ZF=1, SF=0, OF=0).
- `e_cnd` is decoded from `E_ifun` using the registered `cc`, never the same-cycle `e_cf`:
  - 0 always → 1
  - 1 le → (SF^OF)|ZF
  - 2 l → SF^OF
  - 3 e → ZF
  - 4 ne → !ZF
  - 5 ge → !(SF^OF)
  - 6 g → !(SF^OF)&!ZF
  - 7–F → 0
- `e_dstE = (E_icode==CMOVXX && !e_cnd) ? RNONE : E_dstE`.
- M register update, in priority order:
  - `M_bubble` → icode NOP, stat AOK, cnd 0, valE 0, valA 0, dstE RNONE, dstM RNONE.
  - Else `M_stall` → hold all fields.
  - Else load `{E_icode, E_stat, e_cnd, e_valE, E_valA, e_dstE, E_dstM}`.
- Bubble beats stall when both are asserted.
- The CC update is independent of `M_stall`/`M_bubble`.

## Timing
- `e_cnd` and `e_dstE` are combinational from `cc`, `E_ifun` and `E_icode`, valid in the same cycle.
- CC written at edge N is visible on `cc`/`e_cnd` from cycle N+1. Back-to-back OPQ→JXX therefore sees the OPQ flags.
- M outputs have 1-cycle latency.
- Async reset, effective immediately: M register takes the bubble values and `cc`=3'b100.
  - Reset mid-stream discards in-flight contents.
  - The first edge after deassertion loads normally.
- OPQ in E with `m_stat`=ADR in the same cycle: no CC write; the M register still loads the OPQ fields.

## Structure
- Shared package `y86_pkg`: icode constants, stat codes, RNONE, ifun condition constants, CC bit indices.
- One combinational sub-module `cond_eval` (inputs `ifun` and `cc`, output `cnd`). The same sub-module is reused by the branch-misprediction logic.
- The CC register and the M register live in this module.

## Test plan
- Reset: assert `rst` mid-cycle → `cc`=100, `M_icode`=1, `M_dstE`=F, `M_valE`=0 immediately, without waiting for a clock edge.
- OPQ update:
  - OPQ with `e_cf`=010 → next cycle `cc`=010.
  - Then JXX ifun=2 (l) → `e_cnd`=1.
  - Then ifun=3 (e) → 0.
- Exception suppression: OPQ with `e_cf`=100 while `m_stat`=10 (ADR) → `cc` unchanged; same with `W_stat`=11 (INS).
- Cmov not taken:
  - With `cc`=000, CMOVXX ifun=1 (le), `E_dstE`=3 → `e_dstE`=F and `M_dstE`=F.
  - Repeat with ifun=4 (ne) → `e_dstE`=3.
- Stall/bubble:
  - Load `e_valE`=0x7FFF_FFFF_FFFF_FFFF, then `M_stall`=1 for 2 cycles with changed inputs → `M_valE` holds.
  - Then `M_stall`=1 and `M_bubble`=1 together → NOP fields.
- Condition sweep: for every `cc` in 000..111 and ifun 0..7 → `e_cnd` matches the decode rules, with ifun 7 always 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes, register IDs,
// jump/cmov condition function codes and condition-code bit positions.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status codes
    localparam logic [1:0] S_AOK = 2'b00;
    localparam logic [1:0] S_HLT = 2'b01;
    localparam logic [1:0] S_ADR = 2'b10;
    localparam logic [1:0] S_INS = 2'b11;

    // "No register" destination
    localparam logic [3:0] RNONE = 4'hF;

    // Jump / cmov condition function codes
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Bit positions inside the {ZF,SF,OF} condition-code vector
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    // Condition codes after reset: ZF set, SF/OF clear
    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/cond_eval.sv
// Combinational jump/cmov condition decode from the {ZF,SF,OF} codes.
// Kept standalone so branch-misprediction logic can reuse it.
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    output logic       cnd
);

    logic w_zf;
    logic w_lt;

    assign w_zf = cc[CC_ZF];
    // Signed less-than after a compare is SF xor OF
    assign w_lt = cc[CC_SF] ^ cc[CC_OF];

    // Select the condition named by ifun; undefined codes never fire
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = w_lt | w_zf;
            C_L:     cnd = w_lt;
            C_E:     cnd = w_zf;
            C_NE:    cnd = ~w_zf;
            C_GE:    cnd = ~w_lt;
            C_G:     cnd = ~w_lt & ~w_zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_cc_mreg.sv
// Back half of the Y86-64 Execute stage: condition-code register,
// condition evaluation and the E->M pipeline register.
module execute_cc_mreg
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [1:0]   E_stat,
    input  logic [W-1:0] E_valA,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [W-1:0] e_valE,
    input  logic [2:0]   e_cf,
    input  logic [1:0]   m_stat,
    input  logic [1:0]   W_stat,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic         e_cnd,
    output logic [3:0]   e_dstE,
    output logic [2:0]   cc,
    output logic [3:0]   M_icode,
    output logic [1:0]   M_stat,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    logic [2:0]   r_cc;
    logic [3:0]   r_icode;
    logic [1:0]   r_stat;
    logic         r_cnd;
    logic [W-1:0] r_valE;
    logic [W-1:0] r_valA;
    logic [3:0]   r_dstE;
    logic [3:0]   r_dstM;

    logic         w_set_cc;
    logic         w_cnd;
    logic [3:0]   w_dstE;

    // Only an OPQ updates flags, and only while no older instruction
    // downstream has faulted (an exception must not leave CC side effects).
    assign w_set_cc = (E_icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK);

    // Condition uses the registered codes, so OPQ->JXX sees the OPQ flags
    cond_eval u_cond (
        .ifun (E_ifun),
        .cc   (r_cc),
        .cnd  (w_cnd)
    );

    // A not-taken cmov writes nothing
    assign w_dstE = ((E_icode == I_CMOVXX) && !w_cnd) ? RNONE : E_dstE;

    // Condition-code register; independent of M stall/bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cc <= CC_RESET;
        else if (w_set_cc)
            r_cc <= e_cf;
    end

    // E->M register: bubble beats stall, otherwise load Execute results
    always_ff @(posedge clk or posedge rst) begin
        if (rst || M_bubble) begin
            r_icode <= I_NOP;
            r_stat  <= S_AOK;
            r_cnd   <= 1'b0;
            r_valE  <= '0;
            r_valA  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
        end else if (!M_stall) begin
            r_icode <= E_icode;
            r_stat  <= E_stat;
            r_cnd   <= w_cnd;
            r_valE  <= e_valE;
            r_valA  <= E_valA;
            r_dstE  <= w_dstE;
            r_dstM  <= E_dstM;
        end
    end

    assign e_cnd   = w_cnd;
    assign e_dstE  = w_dstE;
    assign cc      = r_cc;
    assign M_icode = r_icode;
    assign M_stat  = r_stat;
    assign M_cnd   = r_cnd;
    assign M_valE  = r_valE;
    assign M_valA  = r_valA;
    assign M_dstE  = r_dstE;
    assign M_dstM  = r_dstM;

endmodule

// File: tb/tb_execute_cc_mreg.sv
// Self-checking bench for execute_cc_mreg: directed steps from the test
// plan followed by random traffic, checked against a behavioural model.
module tb_execute_cc_mreg;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM;
    logic [1:0]   E_stat, m_stat, W_stat;
    logic [W-1:0] E_valA, e_valE;
    logic [2:0]   e_cf;
    logic         M_stall, M_bubble;
    logic         e_cnd;
    logic [3:0]   e_dstE;
    logic [2:0]   cc;
    logic [3:0]   M_icode, M_dstE, M_dstM;
    logic [1:0]   M_stat;
    logic         M_cnd;
    logic [W-1:0] M_valE, M_valA;

    int checks   = 0;
    int failures = 0;

    // Reference model state: flags kept as separate booleans
    bit           ref_zf, ref_sf, ref_of;
    logic [3:0]   ref_icode, ref_dstE, ref_dstM;
    logic [1:0]   ref_stat;
    logic         ref_cnd_r;
    logic [W-1:0] ref_valE, ref_valA;

    always #5 clk = ~clk;

    execute_cc_mreg #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
        .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .e_valE(e_valE), .e_cf(e_cf), .m_stat(m_stat), .W_stat(W_stat),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .e_cnd(e_cnd), .e_dstE(e_dstE), .cc(cc),
        .M_icode(M_icode), .M_stat(M_stat), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Condition as a statement about the last signed comparison
    function automatic bit ref_cond(input logic [3:0] f);
        bit less = (ref_sf != ref_of);
        case (f)
            4'd0: return 1'b1;
            4'd1: return less || ref_zf;
            4'd2: return less;
            4'd3: return ref_zf;
            4'd4: return !ref_zf;
            4'd5: return !less;
            4'd6: return !less && !ref_zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] ref_ccvec();
        return {ref_zf, ref_sf, ref_of};
    endfunction

    task automatic ref_reset();
        ref_zf = 1; ref_sf = 0; ref_of = 0;
        ref_icode = 4'h1; ref_stat = 2'b00; ref_cnd_r = 1'b0;
        ref_valE = '0; ref_valA = '0; ref_dstE = 4'hF; ref_dstM = 4'hF;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".cc"},     64'(cc),      64'(ref_ccvec()));
        chk({tag, ".Micode"}, 64'(M_icode), 64'(ref_icode));
        chk({tag, ".Mstat"},  64'(M_stat),  64'(ref_stat));
        chk({tag, ".Mcnd"},   64'(M_cnd),   64'(ref_cnd_r));
        chk({tag, ".MvalE"},  M_valE,       ref_valE);
        chk({tag, ".MvalA"},  M_valA,       ref_valA);
        chk({tag, ".MdstE"},  64'(M_dstE),  64'(ref_dstE));
        chk({tag, ".MdstM"},  64'(M_dstM),  64'(ref_dstM));
    endtask

    // One cycle: drive, check combinational outputs, clock, check registers
    task automatic step(input string tag,
                        input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [1:0] st, input logic [W-1:0] va,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic [W-1:0] ve, input logic [2:0] cf,
                        input logic [1:0] ms, input logic [1:0] ws,
                        input logic stall, input logic bubble);
        bit c;
        logic [3:0] de_eff;
        E_icode = icode; E_ifun = ifun; E_stat = st; E_valA = va;
        E_dstE = de; E_dstM = dm; e_valE = ve; e_cf = cf;
        m_stat = ms; W_stat = ws; M_stall = stall; M_bubble = bubble;
        #1;
        c = ref_cond(ifun);
        de_eff = (icode == 4'h2 && !c) ? 4'hF : de;
        chk({tag, ".e_cnd"},  64'(e_cnd),  64'(c));
        chk({tag, ".e_dstE"}, 64'(e_dstE), 64'(de_eff));
        @(posedge clk);
        if (icode == 4'h6 && ms == 2'b00 && ws == 2'b00) begin
            ref_zf = cf[2]; ref_sf = cf[1]; ref_of = cf[0];
        end
        if (bubble) begin
            ref_icode = 4'h1; ref_stat = 2'b00; ref_cnd_r = 1'b0;
            ref_valE = '0; ref_valA = '0; ref_dstE = 4'hF; ref_dstM = 4'hF;
        end else if (!stall) begin
            ref_icode = icode; ref_stat = st; ref_cnd_r = c;
            ref_valE = ve; ref_valA = va; ref_dstE = de_eff; ref_dstM = dm;
        end
        #1;
        chk_state(tag);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        // Power-on reset with quiet inputs
        rst = 1'b1;
        E_icode = 4'h1; E_ifun = 4'h0; E_stat = 2'b00; E_valA = '0;
        E_dstE = 4'hF; E_dstM = 4'hF; e_valE = '0; e_cf = 3'b000;
        m_stat = 2'b00; W_stat = 2'b00; M_stall = 1'b0; M_bubble = 1'b0;
        ref_reset();
        #1;
        chk_state("por");
        @(posedge clk); #1;
        rst = 1'b0;
        chk_state("por_hold");

        // OPQ sets SF, then JL taken and JE not taken
        step("opq010", 4'h6, 4'h0, 2'b00, rnd64(), 4'h2, 4'hF, rnd64(), 3'b010, 2'b00, 2'b00, 0, 0);
        chk("cc_after_opq", 64'(cc), 64'h2);
        step("jl",  4'h7, 4'h2, 2'b00, rnd64(), 4'hF, 4'hF, rnd64(), 3'b111, 2'b00, 2'b00, 0, 0);
        chk("jl_cnd_reg", 64'(M_cnd), 64'h1);
        step("je",  4'h7, 4'h3, 2'b00, rnd64(), 4'hF, 4'hF, rnd64(), 3'b111, 2'b00, 2'b00, 0, 0);
        chk("je_cnd_reg", 64'(M_cnd), 64'h0);

        // Faulting instruction downstream blocks the CC write, M still loads
        step("opq_madr", 4'h6, 4'h1, 2'b00, rnd64(), 4'h5, 4'hF, rnd64(), 3'b100, 2'b10, 2'b00, 0, 0);
        chk("cc_madr", 64'(cc), 64'h2);
        step("opq_wins", 4'h6, 4'h1, 2'b00, rnd64(), 4'h5, 4'hF, rnd64(), 3'b100, 2'b00, 2'b11, 0, 0);
        chk("cc_wins", 64'(cc), 64'h2);

        // Cmov with cc=000: le not taken, ne taken
        step("opq000", 4'h6, 4'h0, 2'b00, rnd64(), 4'h1, 4'hF, rnd64(), 3'b000, 2'b00, 2'b00, 0, 0);
        step("cmovle", 4'h2, 4'h1, 2'b00, rnd64(), 4'h3, 4'hF, rnd64(), 3'b000, 2'b00, 2'b00, 0, 0);
        chk("cmovle_MdstE", 64'(M_dstE), 64'hF);
        step("cmovne", 4'h2, 4'h4, 2'b00, rnd64(), 4'h3, 4'hF, rnd64(), 3'b000, 2'b00, 2'b00, 0, 0);
        chk("cmovne_MdstE", 64'(M_dstE), 64'h3);

        // Stall holds the max positive valE, then bubble overrides stall
        step("load7f", 4'h3, 4'h0, 2'b00, rnd64(), 4'h4, 4'hF, 64'h7FFF_FFFF_FFFF_FFFF, 3'b000, 2'b00, 2'b00, 0, 0);
        step("stall1", 4'h5, 4'h0, 2'b01, rnd64(), 4'hF, 4'h6, rnd64(), 3'b000, 2'b00, 2'b00, 1, 0);
        step("stall2", 4'h4, 4'h0, 2'b10, rnd64(), 4'hF, 4'h7, rnd64(), 3'b000, 2'b00, 2'b00, 1, 0);
        chk("stall_valE", M_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        step("stallbub", 4'h3, 4'h0, 2'b00, rnd64(), 4'h4, 4'h8, rnd64(), 3'b000, 2'b00, 2'b00, 1, 1);
        chk("bub_icode", 64'(M_icode), 64'h1);

        // Condition sweep over every flag combination and ifun 0..7
        for (int c = 0; c < 8; c++) begin
            step("sw_set", 4'h6, 4'h0, 2'b00, rnd64(), 4'h1, 4'hF, rnd64(), 3'(c), 2'b00, 2'b00, 0, 0);
            for (int f = 0; f < 8; f++)
                step("sweep", 4'h7, 4'(f), 2'b00, rnd64(), 4'hF, 4'hF, rnd64(), 3'b000, 2'b00, 2'b00, 0, 0);
        end

        // Mid-cycle reset discards in-flight state without a clock edge
        step("pre_rst", 4'h6, 4'h0, 2'b00, rnd64(), 4'h2, 4'h9, rnd64(), 3'b011, 2'b00, 2'b00, 0, 0);
        #2;
        rst = 1'b1;
        ref_reset();
        #1;
        chk_state("midrst");
        #2;
        rst = 1'b0;
        step("post_rst", 4'h5, 4'h0, 2'b00, rnd64(), 4'hF, 4'h4, rnd64(), 3'b000, 2'b00, 2'b00, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] ms, ws;
            ms = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00;
            ws = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00;
            step("rnd", 4'($urandom_range(0, 11)), 4'($urandom()), 2'($urandom()),
                 rnd64(), 4'($urandom()), 4'($urandom()), rnd64(), 3'($urandom()),
                 ms, ws, ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
